// File: rtl/fir_mac_serial.sv
// Serial N-tap FIR: one multiply-accumulate per cycle, programmable coefficients, rounded output.
// Define FIR_SATURATE_EN to clamp the output to the DATA_W range instead of wrapping.
module fir_mac_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic [1:0]                 dbg_state
);

  localparam int AW     = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [AW:0]            TAPS_L   = (AW+1)'(TAPS);
  localparam logic [AW-1:0]          LAST_IDX = AW'(TAPS - 1);
  localparam logic signed [ACC_W:0]  ROUND_K  = (SHIFT > 0) ? ((ACC_W+1)'(1) <<< RSH) : '0;
  localparam logic signed [ACC_W:0]  SAT_MAX  = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]  SAT_MIN  = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef FIR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Handshake semantics: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and ready/valid are registered (no input-to-output paths).

  logic [1:0]               state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            idx;

  // A coefficient written in the same cycle a sample is accepted must not affect that sample,
  // so the overwritten value is remembered for the duration of the computation.
  logic                     ovr_valid;
  logic [AW-1:0]            ovr_addr;
  logic signed [COEF_W-1:0] ovr_data;

  logic                     addr_ok;
  logic signed [COEF_W-1:0] cur_coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] result;

  assign dbg_state = state;
  assign addr_ok   = ({1'b0, coef_addr} < TAPS_L);

  always_comb begin
    cur_coef = (ovr_valid && (ovr_addr == idx)) ? ovr_data : c[idx];
    prod     = PROD_W'(cur_coef) * PROD_W'(x[idx]);
    acc_sum  = acc + ACC_W'(prod);
    rounded  = (ACC_W+1)'(acc_sum) + ROUND_K;
    shifted  = rounded >>> SHIFT;
    result   = shifted[DATA_W-1:0];
    if (SAT_EN && (shifted > SAT_MAX)) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (SAT_EN && (shifted < SAT_MIN)) begin
      result = SAT_MIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      idx       <= '0;
      ovr_valid <= 1'b0;
      ovr_addr  <= '0;
      ovr_data  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= COEF_W'(1);
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (coef_we && addr_ok) begin
            c[coef_addr] <= coef_data;
          end
          if (in_valid) begin
            x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              x[k] <= x[k-1];
            end
            acc       <= '0;
            idx       <= '0;
            state     <= S_MAC;
            in_ready  <= 1'b0;
            ovr_valid <= coef_we && addr_ok;
            ovr_addr  <= coef_addr;
            ovr_data  <= c[coef_addr];
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (idx == LAST_IDX) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_data  <= result;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
